// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types: store-buffer entry, depth and drain states
// Purpose: types shared by store_buffer and store_buffer_fwd.
//   SB_DEPTH    default store-buffer depth (power of two, >= 2)
//   sb_entry_t  one committed store: valid, rob_tag, mem_wdata, addr, mem_wmask
//   sb_state_t  drain FSM states
package rv32i_types;

  localparam int SB_DEPTH  = 8;
  localparam int ROB_TAG_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          mem_wdata;
    logic [31:0]          addr;
    logic [3:0]           mem_wmask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_WAIT = 1'b1
  } sb_state_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// rtl/store_buffer_fwd.sv - youngest-match per-byte forwarding select over the store buffer
// Purpose: for each byte of the load, pick the youngest valid entry in the same
//   word that writes that byte; also flag whether any entry overlaps the load.
// Ports:
//   i_entries   entry array (index = FIFO slot)
//   i_tail      tail slot index (slot the next enqueue will use)
//   i_ld_addr   load address; only [31:2] takes part in the match
//   i_ld_rmask  load byte read mask
//   o_fwd_mask  bytes supplied by the buffer
//   o_fwd_data  supplied bytes, zero outside o_fwd_mask
//   o_overlap   some valid entry word-matches and shares a byte with the load
module store_buffer_fwd
  import rv32i_types::sb_entry_t;
#(
  parameter int SB_DEPTH = 8,
  localparam int IDX_W = $clog2(SB_DEPTH)
) (
  input  sb_entry_t        i_entries [SB_DEPTH],
  input  logic [IDX_W-1:0] i_tail,
  input  logic [31:0]      i_ld_addr,
  input  logic [3:0]       i_ld_rmask,
  output logic [3:0]       o_fwd_mask,
  output logic [31:0]      o_fwd_data,
  output logic             o_overlap
);

  logic [IDX_W-1:0] w_idx;
  sb_entry_t        w_e;
  logic             w_unused;

  // Walk from the tail slot forward through the wrap: live entries are then
  // visited oldest to youngest, so a later hit overwrites an older one.
  always_comb begin
    o_fwd_mask = '0;
    o_fwd_data = '0;
    o_overlap  = 1'b0;
    w_idx      = '0;
    w_e        = '0;
    w_unused   = ^i_ld_addr[1:0];
    for (int j = 0; j < SB_DEPTH; j++) begin
      w_idx    = i_tail + IDX_W'(j);
      w_e      = i_entries[w_idx];
      w_unused = w_unused ^ (^w_e.rob_tag);
      if (w_e.valid && (w_e.addr[31:2] == i_ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (w_e.mem_wmask[b] && i_ld_rmask[b]) begin
            o_fwd_mask[b]        = 1'b1;
            o_fwd_data[8*b +: 8] = w_e.mem_wdata[8*b +: 8];
            o_overlap            = 1'b1;
          end
        end
      end
      w_unused = w_unused ^ (^w_e.addr[1:0]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - commit-side store buffer with in-order drain and load lookup
// Purpose: buffers retired stores in a FIFO, drains them in order to the data
//   memory write port, and answers load lookups (forwarding or stall).
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   -> per-byte store-to-load forwarding, ld_conflict tied 0
//   undefined -> no forwarding, ld_conflict flags any overlapping entry
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   enq_valid/enq_ready/enq_entry    store commit from the ROB
//   ld_addr/ld_rmask                 load being checked by the LSQ
//   fwd_mask/fwd_data/ld_conflict    lookup result (combinational)
//   wr_req/wr_addr/wr_wmask/wr_wdata memory write request, held until wr_resp
//   wr_resp                          one-cycle completion pulse
//   empty/count                      occupancy
module store_buffer
  import rv32i_types::sb_entry_t;
  import rv32i_types::sb_state_t;
  import rv32i_types::SB_IDLE;
  import rv32i_types::SB_WAIT;
#(
  parameter int SB_DEPTH = 8,
  localparam int IDX_W = $clog2(SB_DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  sb_entry_t        enq_entry,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  output logic [3:0]       fwd_mask,
  output logic [31:0]      fwd_data,
  output logic             ld_conflict,
  output logic             wr_req,
  output logic [31:0]      wr_addr,
  output logic [3:0]       wr_wmask,
  output logic [31:0]      wr_wdata,
  input  logic             wr_resp,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  sb_entry_t        r_entries [SB_DEPTH];
  logic [IDX_W:0]   r_head;
  logic [IDX_W:0]   r_tail;
  sb_state_t        r_state;
  logic [31:0]      r_wr_addr;
  logic [3:0]       r_wr_wmask;
  logic [31:0]      r_wr_wdata;

  sb_state_t        w_state_next;
  logic             w_full;
  logic             w_enq;
  logic             w_pop;
  logic             w_latch;
  logic [3:0]       w_fwd_mask;
  logic [31:0]      w_fwd_data;
  logic             w_overlap;
  logic             w_unused;

  assign w_full    = (r_head[IDX_W] != r_tail[IDX_W]) &&
                     (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]);
  assign empty     = (r_head == r_tail);
  assign count     = r_tail - r_head;
  // No bypass: a pop in the same cycle does not open a slot for the enqueue.
  assign enq_ready = !w_full;
  assign w_enq     = enq_valid && !w_full;

  assign wr_addr   = r_wr_addr;
  assign wr_wmask  = r_wr_wmask;
  assign wr_wdata  = r_wr_wdata;

  always_ff @(posedge clk) begin
    r_state <= rst ? SB_IDLE : w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_pop        = 1'b0;
    wr_req       = 1'b0;
    case (r_state)
      SB_IDLE: begin
        if (!empty) begin
          w_latch      = 1'b1;
          w_state_next = SB_WAIT;
        end
      end
      SB_WAIT: begin
        wr_req = 1'b1;
        if (wr_resp) begin
          w_pop        = 1'b1;
          w_state_next = SB_IDLE;
        end
      end
      default: w_state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_wr_wmask <= '0;
      r_wr_wdata <= '0;
    end else if (w_latch) begin
      r_wr_addr  <= {r_entries[r_head[IDX_W-1:0]].addr[31:2], 2'b00};
      r_wr_wmask <= r_entries[r_head[IDX_W-1:0]].mem_wmask;
      r_wr_wdata <= r_entries[r_head[IDX_W-1:0]].mem_wdata;
    end else if (w_pop) begin
      r_wr_addr  <= '0;
      r_wr_wmask <= '0;
      r_wr_wdata <= '0;
    end
  end

  // The in-flight head keeps its valid bit until wr_resp, so lookups still see it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_tail[IDX_W-1:0]] <= '{valid:     1'b1,
                                          rob_tag:   enq_entry.rob_tag,
                                          mem_wdata: enq_entry.mem_wdata,
                                          addr:      enq_entry.addr,
                                          mem_wmask: enq_entry.mem_wmask};
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_entries[r_head[IDX_W-1:0]].valid <= 1'b0;
        r_head <= r_head + 1'b1;
      end
    end
  end

  store_buffer_fwd #(.SB_DEPTH(SB_DEPTH)) u_fwd (
    .i_entries  (r_entries),
    .i_tail     (r_tail[IDX_W-1:0]),
    .i_ld_addr  (ld_addr),
    .i_ld_rmask (ld_rmask),
    .o_fwd_mask (w_fwd_mask),
    .o_fwd_data (w_fwd_data),
    .o_overlap  (w_overlap)
  );

`ifdef STORE_BUFFER_FWD_EN
  // Uncovered bytes are already current in memory, so a load never has to wait.
  assign fwd_mask    = w_fwd_mask;
  assign fwd_data    = w_fwd_data;
  assign ld_conflict = 1'b0;
  assign w_unused    = w_overlap ^ enq_entry.valid;
`else
  assign fwd_mask    = '0;
  assign fwd_data    = '0;
  assign ld_conflict = w_overlap;
  assign w_unused    = (^w_fwd_mask) ^ (^w_fwd_data) ^ enq_entry.valid;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
  import rv32i_types::sb_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  sb_entry_t   enq_entry;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        ld_conflict;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wmask;
  logic [31:0] wr_wdata;
  logic        wr_resp;
  logic        empty;
  logic [3:0]  count;

  store_buffer #(.SB_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_entry(enq_entry),
    .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .fwd_mask(fwd_mask), .fwd_data(fwd_data), .ld_conflict(ld_conflict),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wmask(wr_wmask), .wr_wdata(wr_wdata),
    .wr_resp(wr_resp), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  fmask;
    logic [31:0] fdata;
    logic        conf;
  } lk_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  lk_vec_t lk_tab [6];
  st_t     q [$];
  int      checks = 0;
  int      errors = 0;
  int      pops   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive enqueue/response, score the drain against the model queue.
  task automatic step(input logic ev, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic r, output logic acc);
    logic pop;
    st_t  s;
    enq_valid           = ev;
    enq_entry.valid     = 1'b0;
    enq_entry.rob_tag   = a[7:2];
    enq_entry.addr      = a;
    enq_entry.mem_wdata = d;
    enq_entry.mem_wmask = m;
    wr_resp             = r;
    acc = ev && enq_ready;
    pop = r && wr_req;
    if (pop) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got addr 0x%0h expected no request", wr_addr);
      end else begin
        s = q.pop_front();
        chk("drain_addr", wr_addr, s.a);
        chk("drain_data", wr_wdata, s.d);
        chk("drain_mask", wr_wmask, s.m);
        pops++;
      end
    end
    if (acc) begin
      s.a = a; s.d = d; s.m = m;
      q.push_back(s);
    end
    tick();
    enq_valid = 1'b0;
    wr_resp   = 1'b0;
    chk("count", count, q.size());
  endtask

  initial begin
    logic        acc;
    int          n;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic        e_conf;

    lk_tab[0] = '{32'h0000_2000, 4'b1111, 4'b1111, 32'h1122_1111, 1'b1};
    lk_tab[1] = '{32'h0000_2004, 4'b1111, 4'b0000, 32'h0000_0000, 1'b0};
    lk_tab[2] = '{32'h0000_2002, 4'b1100, 4'b1100, 32'h1122_0000, 1'b1};
    lk_tab[3] = '{32'h0000_3000, 4'b1111, 4'b0000, 32'h0000_0000, 1'b0};
    lk_tab[4] = '{32'h0000_2000, 4'b0100, 4'b0100, 32'h0022_0000, 1'b1};
    lk_tab[5] = '{32'h0000_2001, 4'b0001, 4'b0001, 32'h0000_0011, 1'b1};

    rst = 1'b1; enq_valid = 1'b0; enq_entry = '0; wr_resp = 1'b0;
    ld_addr = 32'h0000_2000; ld_rmask = 4'hF;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_fwd_mask", fwd_mask, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_conflict", ld_conflict, 0);

    // Single store: request two cycles after acceptance, held until wr_resp.
    enq_valid = 1'b1;
    enq_entry = '{valid: 1'b0, rob_tag: 6'd1, mem_wdata: 32'hAABB_CCDD,
                  addr: 32'h1000_0004, mem_wmask: 4'b0011};
    tick();
    enq_valid = 1'b0;
    chk("single_count", count, 1);
    chk("single_req_t1", wr_req, 0);
    tick();
    chk("single_req_t2", wr_req, 1);
    chk("single_addr", wr_addr, 32'h1000_0004);
    chk("single_mask", wr_wmask, 4'b0011);
    chk("single_data", wr_wdata, 32'hAABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_req", wr_req, 1);
      chk("hold_addr", wr_addr, 32'h1000_0004);
      chk("hold_data", wr_wdata, 32'hAABB_CCDD);
    end
    wr_resp = 1'b1;
    tick();
    wr_resp = 1'b0;
    chk("single_empty", empty, 1);
    chk("single_req_low", wr_req, 0);
    chk("single_mask_zero", wr_wmask, 0);
    tick();
    chk("idle_gap_req", wr_req, 0);

    // Lookup table against two overlapping stores to the same word.
    step(1'b1, 32'h0000_2000, 32'h1111_1111, 4'b1111, 1'b0, acc);
    step(1'b1, 32'h0000_2000, 32'h0022_0000, 4'b0100, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      ld_addr  = lk_tab[i].addr;
      ld_rmask = lk_tab[i].rmask;
`ifdef STORE_BUFFER_FWD_EN
      e_mask = lk_tab[i].fmask;
      e_data = lk_tab[i].fdata;
      e_conf = 1'b0;
`else
      e_mask = 4'b0000;
      e_data = 32'h0;
      e_conf = lk_tab[i].conf;
`endif
      #1;
      chk($sformatf("lk%0d_fwd_mask", i), fwd_mask, e_mask);
      chk($sformatf("lk%0d_fwd_data", i), fwd_data, e_data);
      chk($sformatf("lk%0d_conflict", i), ld_conflict, e_conf);
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      step(1'b0, 32'h0, 32'h0, 4'h0, wr_req, acc);
    end
    chk("lk_drained", q.size(), 0);
    chk("lk_empty", empty, 1);
    ld_addr = 32'h0000_2002; ld_rmask = 4'b1100;
    #1;
    chk("post_drain_conflict", ld_conflict, 0);
    chk("post_drain_fwd_mask", fwd_mask, 0);

    // Full, dropped enqueue, no bypass on pop, simultaneous push/pop, wrap order.
    pops = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h0000_4000 + 32'(4 * n), 32'hC0DE_0000 + 32'(n), 4'hF, 1'b0, acc);
      if (acc) n++;
    end
    chk("full_enq_ready", enq_ready, 0);
    chk("full_count", count, 8);
    chk("full_wr_req", wr_req, 1);
    step(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 4'hF, 1'b0, acc);
    chk("ninth_dropped", acc, 0);
    step(1'b1, 32'h0000_4000 + 32'(4 * n), 32'hC0DE_0000 + 32'(n), 4'hF, 1'b1, acc);
    chk("no_bypass", acc, 0);
    chk("no_bypass_count", count, 7);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, acc);
    chk("simul_req", wr_req, 1);
    step(1'b1, 32'h0000_4000 + 32'(4 * n), 32'hC0DE_0000 + 32'(n), 4'hF, 1'b1, acc);
    chk("simul_accept", acc, 1);
    chk("simul_count", count, 7);
    if (acc) n++;
    for (int c = 0; c < 400 && (n < 20 || q.size() != 0); c++) begin
      step((n < 20) && (c % 3 != 0), 32'h0000_4000 + 32'(4 * n),
           32'hC0DE_0000 + 32'(n), 4'hF, wr_req, acc);
      if (acc) n++;
    end
    chk("wrap_enqueued", n, 20);
    chk("wrap_drained", pops, 20);
    chk("wrap_empty", empty, 1);

    // Reset while a request is outstanding.
    step(1'b1, 32'h0000_6000, 32'h5555_AAAA, 4'hF, 1'b0, acc);
    tick();
    chk("mid_req", wr_req, 1);
    rst = 1'b1;
    tick();
    ld_addr = 32'h0000_6000; ld_rmask = 4'hF;
    #1;
    chk("mid_rst_req", wr_req, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_fwd_mask", fwd_mask, 0);
    chk("mid_rst_conflict", ld_conflict, 0);
    rst = 1'b0;
    q.delete();
    tick();
    chk("post_rst_req", wr_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
